// File: rtl/color_transform_engine.sv
// Streams an RGB565 frame from a source SRAM region to a destination region,
// applying one of four per-frame transforms (pass, grayscale, invert, threshold).
module color_transform_engine #(
  parameter int unsigned ADDR_W       = 20,
  parameter int unsigned SRC_BASE     = 0,
  parameter int unsigned DST_BASE     = 240000,
  parameter int unsigned READ_CYCLES  = 2,
  parameter int unsigned WRITE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_transform,
  input  logic [1:0]        iMode,
  input  logic [7:0]        iThresh,
  input  logic [9:0]        iCol_Max,
  input  logic [9:0]        iRow_Max,
  output logic              oBusy,
  output logic              oDone,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_WE_N,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  inout  wire  [15:0]       oSRAM_DATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_CALC,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state, state_nx;
  logic [2:0]        wait_cnt;
  logic [ADDR_W-1:0] idx, n_pix, n_calc;
  logic [1:0]        mode;
  logic [7:0]        thresh;
  logic [15:0]       pix, result, calc_out;
  logic [7:0]        r8, g8, b8, luma;
  logic [15:0]       y_acc;
  logic              last_read, last_write, last_pix;

  // Product is taken modulo 2^ADDR_W, so truncating the operands first is exact.
  assign n_calc     = ADDR_W'(iCol_Max) * ADDR_W'(iRow_Max);
  assign last_read  = (wait_cnt == 3'(READ_CYCLES - 1));
  assign last_write = (wait_cnt == 3'(WRITE_CYCLES - 1));
  assign last_pix   = (idx == n_pix - ADDR_W'(1));

  assign r8    = {pix[15:11], pix[15:13]};
  assign g8    = {pix[10:5],  pix[10:9]};
  assign b8    = {pix[4:0],   pix[4:2]};
  assign y_acc = 16'd77 * 16'(r8) + 16'd150 * 16'(g8) + 16'd29 * 16'(b8);
  assign luma  = y_acc[15:8];

  always_comb begin
    calc_out = pix;
    case (mode)
      2'd0: calc_out = pix;
      2'd1: calc_out = {luma[7:3], luma[7:2], luma[7:3]};
      2'd2: calc_out = ~pix;
      2'd3: calc_out = (luma >= thresh) ? 16'hFFFF : 16'h0000;
      default: calc_out = pix;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start_transform) state_nx = (n_calc == '0) ? S_DONE : S_READ;
      S_READ:  if (last_read) state_nx = S_CALC;
      S_CALC:  state_nx = S_WRITE;
      S_WRITE: if (last_write) state_nx = last_pix ? S_DONE : S_READ;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      idx      <= '0;
      n_pix    <= '0;
      mode     <= '0;
      thresh   <= '0;
      pix      <= '0;
      result   <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (start_transform) begin
          mode     <= iMode;
          thresh   <= iThresh;
          n_pix    <= n_calc;
          idx      <= '0;
          wait_cnt <= '0;
        end
        S_READ: begin
          if (last_read) begin
            pix      <= oSRAM_DATA;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        S_CALC: result <= calc_out;
        S_WRITE: begin
          if (last_write) begin
            wait_cnt <= '0;
            if (!last_pix) idx <= idx + ADDR_W'(1);
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and address decode straight from the state register, so the
  // read and write enables can never overlap.
  always_comb begin
    oSRAM_ADDR = '0;
    case (state)
      S_READ:  oSRAM_ADDR = ADDR_W'(SRC_BASE) + idx;
      S_WRITE: oSRAM_ADDR = ADDR_W'(DST_BASE) + idx;
      default: oSRAM_ADDR = '0;
    endcase
  end

  assign oSRAM_OE_N = (state != S_READ);
  assign oSRAM_WE_N = (state != S_WRITE);
  assign oBusy      = (state != S_IDLE);
  assign oDone      = (state == S_DONE);
  assign oSRAM_DATA = (state == S_WRITE) ? result : 16'hzzzz;

endmodule

// File: tb/tb_color_transform_engine.sv
// Directed bench for color_transform_engine: SRAM model, frame runs per mode,
// zero-size frame, ignored starts, mid-frame reset and a slow-timing instance.
module tb_color_transform_engine;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic [1:0]  mode = '0;
  logic [7:0]  thresh = '0;
  logic [9:0]  cols = '0;
  logic [9:0]  rows = '0;
  logic        busy, done, oe_n, we_n;
  logic        busy2, done2, oe2_n, we2_n;
  logic [19:0] addr, addr2;
  wire  [15:0] bus, bus2;

  logic [15:0] src_mem [0:255];
  logic [15:0] dst_mem [0:255];
  logic [15:0] dst2_last = '0;
  logic [15:0] rd_val, rd_val2;
  int          oe_low = 0, we_low = 0, overlap = 0, done_cnt = 0;
  int          oe2_low = 0, we2_low = 0;
  int          checks = 0, failures = 0;
  int          cyc, snap_oe, snap_we, snap_done, k;

  always #5 clk = ~clk;

  color_transform_engine dut (
    .clk(clk), .rst_n(rst_n), .start_transform(start), .iMode(mode),
    .iThresh(thresh), .iCol_Max(cols), .iRow_Max(rows), .oBusy(busy),
    .oDone(done), .oSRAM_OE_N(oe_n), .oSRAM_WE_N(we_n), .oSRAM_ADDR(addr),
    .oSRAM_DATA(bus)
  );

  color_transform_engine #(.READ_CYCLES(3), .WRITE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start_transform(start2), .iMode(mode),
    .iThresh(thresh), .iCol_Max(cols), .iRow_Max(rows), .oBusy(busy2),
    .oDone(done2), .oSRAM_OE_N(oe2_n), .oSRAM_WE_N(we2_n), .oSRAM_ADDR(addr2),
    .oSRAM_DATA(bus2)
  );

  // SRAM model: source reads answer combinationally while OE_N is low.
  always_comb rd_val  = src_mem[addr[7:0]];
  always_comb rd_val2 = src_mem[addr2[7:0]];
  assign bus  = oe_n  ? 16'hzzzz : rd_val;
  assign bus2 = oe2_n ? 16'hzzzz : rd_val2;

  always @(posedge clk) begin
    if (!we_n) dst_mem[8'(addr - 20'd240000)] <= bus;
    if (!we2_n) dst2_last <= bus2;
    if (!oe_n) oe_low <= oe_low + 1;
    if (!we_n) we_low <= we_low + 1;
    if (!oe2_n) oe2_low <= oe2_low + 1;
    if (!we2_n) we2_low <= we2_low + 1;
    if ((!oe_n && !we_n) || (!oe2_n && !we2_n)) overlap <= overlap + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a frame on dut, scrambles the config inputs while busy, and
  // returns the cycle index (start edge = 1) at which oDone was seen.
  task automatic run_frame(input logic [9:0] c, input logic [9:0] r,
                           input logic [1:0] m, input logic [7:0] t, output int n);
    @(negedge clk);
    cols = c; rows = r; mode = m; thresh = t; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cols = ~c; rows = ~r; mode = ~m; thresh = ~t;
    n = 1;
    while (!done && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      src_mem[i] = '0;
      dst_mem[i] = '0;
    end

    // Reset state
    #7;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_oe_n", oe_n, 1);
    check("rst_we_n", we_n, 1);
    check("rst_addr", addr, 0);
    @(negedge clk); rst_n = 1'b1;

    // 2x2 pass-through
    src_mem[0] = 16'h0001; src_mem[1] = 16'h0002;
    src_mem[2] = 16'h0003; src_mem[3] = 16'h0004;
    run_frame(10'd2, 10'd2, 2'd0, 8'd0, cyc);
    check("pass_cycles", cyc, 17);
    check("pass_d0", dst_mem[0], 16'h0001);
    check("pass_d1", dst_mem[1], 16'h0002);
    check("pass_d2", dst_mem[2], 16'h0003);
    check("pass_d3", dst_mem[3], 16'h0004);
    check("pass_busy_after", busy, 0);

    // Grayscale
    src_mem[0] = 16'hF800; src_mem[1] = 16'hFFFF;
    src_mem[2] = 16'h0000; src_mem[3] = 16'h07E0;
    run_frame(10'd4, 10'd1, 2'd1, 8'd0, cyc);
    check("gray_cycles", cyc, 17);
    check("gray_red", dst_mem[0], 16'h4A69);
    check("gray_white", dst_mem[1], 16'hFFFF);
    check("gray_black", dst_mem[2], 16'h0000);
    check("gray_green", dst_mem[3], 16'h94B2);

    // Threshold at the Y boundary, then invert
    src_mem[0] = 16'hF800;
    run_frame(10'd1, 10'd1, 2'd3, 8'd76, cyc);
    check("thr76_cycles", cyc, 5);
    check("thr76_out", dst_mem[0], 16'hFFFF);
    run_frame(10'd1, 10'd1, 2'd3, 8'd77, cyc);
    check("thr77_out", dst_mem[0], 16'h0000);
    src_mem[0] = 16'h1234;
    run_frame(10'd1, 10'd1, 2'd2, 8'd0, cyc);
    check("inv_cycles", cyc, 5);
    check("inv_out", dst_mem[0], 16'hEDCB);

    // Zero-size frame, with start held into the DONE cycle
    snap_oe = oe_low; snap_we = we_low; snap_done = done_cnt;
    @(negedge clk);
    cols = 10'd0; rows = 10'd300; mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    check("zero_done_next", done, 1);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("zero_busy_after", busy, 0);
    check("zero_oe_low", oe_low - snap_oe, 0);
    check("zero_we_low", we_low - snap_we, 0);
    check("zero_done_count", done_cnt - snap_done, 1);

    // Start pulse during a busy frame is ignored
    snap_done = done_cnt;
    src_mem[0] = 16'h5A5A;
    @(negedge clk);
    cols = 10'd1; rows = 10'd1; mode = 2'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("ign_busy", busy, 0);
    check("ign_done_count", done_cnt - snap_done, 1);
    check("ign_data", dst_mem[0], 16'h5A5A);

    // Reset in the middle of a frame, then a clean rerun
    for (int i = 0; i < 256; i++) src_mem[i] = 16'(i * 257 + 5);
    @(negedge clk);
    cols = 10'd20; rows = 10'd10; mode = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    k = 0;
    while (we_n && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_in_write", we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("abort_oe_n", oe_n, 1);
    check("abort_we_n", we_n, 1);
    check("abort_busy", busy, 0);
    check("abort_addr", addr, 0);
    @(negedge clk); rst_n = 1'b1;
    run_frame(10'd20, 10'd10, 2'd2, 8'd0, cyc);
    check("rerun_cycles", cyc, 801);
    check("rerun_d0", dst_mem[0], 16'hFFFA);
    check("rerun_d199", dst_mem[199], 16'h3833);

    // Slow-timing instance: 3-cycle reads, 2-cycle writes
    src_mem[0] = 16'hABCD;
    snap_oe = oe2_low; snap_we = we2_low;
    @(negedge clk);
    cols = 10'd1; rows = 10'd1; mode = 2'd0; start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    cyc = 1;
    while (!done2 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
    check("slow_cycles", cyc, 7);
    check("slow_oe_low", oe2_low - snap_oe, 3);
    check("slow_we_low", we2_low - snap_we, 2);
    check("slow_data", dst2_last, 16'hABCD);

    check("no_oe_we_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
